// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller.
//   ctrl_state_e  : FSM encoding; also exposed on ctrlState for debug
//   stage_en_t    : load enables {pc, id, ex, mem, wb}
//   stage_flush_t : bubble inserts {id, ex, wb}
package pipeline_controller_pkg;

  localparam int REG_W = 5;

  // Encoding 3 is never entered; the FSM treats it like ERROR.
  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_ERROR    = 2'd2,
    CTRL_RSVD     = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc;
    logic id;
    logic ex;
    logic mem;
    logic wb;
  } stage_en_t;

  typedef struct packed {
    logic id;
    logic ex;
    logic wb;
  } stage_flush_t;

endpackage

// File: rtl/pipeline_controller_load_use_detect.sv
// Combinational load-use hazard detector.
//   idRs_i/idRt_i         : source registers of the instruction in ID
//   idUsesRs_i/idUsesRt_i : ID instruction really reads that source
//   exMemRead_i           : EX instruction is a load
//   exWriteReg_i          : destination of the EX instruction
//   loadUse_o             : ID needs the loaded value one cycle too early
module load_use_detect
  import pipeline_controller_pkg::*;
(
  input  logic [REG_W-1:0] idRs_i,
  input  logic [REG_W-1:0] idRt_i,
  input  logic             idUsesRs_i,
  input  logic             idUsesRt_i,
  input  logic             exMemRead_i,
  input  logic [REG_W-1:0] exWriteReg_i,
  output logic             loadUse_o
);

  logic rsHit, rtHit;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign rsHit     = idUsesRs_i && (idRs_i == exWriteReg_i);
  assign rtHit     = idUsesRt_i && (idRt_i == exWriteReg_i);
  assign loadUse_o = exMemRead_i && (exWriteReg_i != '0) && (rsHit || rtHit);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: PC / stage-register load enables and bubble inserts.
// Handles data-memory waits, branches resolved in EX and load-use interlocks,
// and keeps saturating stall/flush counters plus a sticky memory-timeout flag.
//   clk, rstN                 : clock, async active-low reset
//   idRs..exWriteReg          : hazard-detection fields from ID and EX
//   exBranchTaken             : EX redirects the PC
//   memReq, memReady          : MEM access request / completion this cycle
//   pcEn..wbEn                : load enables (combinational)
//   idFlush, exFlush, wbFlush : load a NOP bubble (combinational)
//   memStart                  : pulse that launches a data-memory access
//   memTimeout                : sticky error, cleared only by reset
//   ctrlState                 : FSM state (debug)
//   stallCycles, flushCount   : saturating performance counters
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exWriteReg,
  input  logic             exBranchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcEn,
  output logic             idEn,
  output logic             exEn,
  output logic             memEn,
  output logic             wbEn,
  output logic             idFlush,
  output logic             exFlush,
  output logic             wbFlush,
  output logic             memStart,
  output logic             memTimeout,
  output logic [1:0]       ctrlState,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last not-ready wait cycle before the count would reach MEM_TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              timeout_q, timeout_d;

  stage_en_t    en_c;
  stage_flush_t fl_c;
  logic         memStart_c;
  logic         stallInc, flushInc;
  logic         resolve;
  logic         loadUse;

  load_use_detect u_load_use (
    .idRs_i       (idRs),
    .idRt_i       (idRt),
    .idUsesRs_i   (idUsesRs),
    .idUsesRt_i   (idUsesRt),
    .exMemRead_i  (exMemRead),
    .exWriteReg_i (exWriteReg),
    .loadUse_o    (loadUse)
  );

  always_comb begin
    en_c       = '0;
    fl_c       = '0;
    memStart_c = 1'b0;
    stallInc   = 1'b0;
    flushInc   = 1'b0;
    resolve    = 1'b0;
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    timeout_d  = timeout_q;

    case (state_q)
      CTRL_RUN: begin
        if (memReq && !memReady) begin
          // Freeze everything; the branch (if any) stays in EX until release.
          memStart_c = 1'b1;
          fl_c.wb    = 1'b1;
          stallInc   = 1'b1;
          waitCnt_d  = WAIT_W'(1);
          state_d    = CTRL_MEM_WAIT;
        end else begin
          memStart_c = memReq;
          resolve    = 1'b1;
        end
      end
      CTRL_MEM_WAIT: begin
        if (memReady) begin
          // Release cycle is a normal cycle and is not counted as a stall.
          resolve   = 1'b1;
          waitCnt_d = '0;
          state_d   = CTRL_RUN;
        end else begin
          fl_c.wb  = 1'b1;
          stallInc = 1'b1;
          if (waitCnt_q >= WAIT_LAST) begin
            state_d   = CTRL_ERROR;
            timeout_d = 1'b1;
          end else begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = CTRL_ERROR;
        timeout_d = 1'b1;
      end
    endcase

    // Branch outranks load-use: the dependent ID instruction is squashed anyway.
    if (resolve) begin
      if (exBranchTaken) begin
        en_c     = '1;
        fl_c.id  = 1'b1;
        fl_c.ex  = 1'b1;
        flushInc = 1'b1;
      end else if (loadUse) begin
        en_c     = '{pc: 1'b0, id: 1'b0, ex: 1'b1, mem: 1'b1, wb: 1'b1};
        fl_c.ex  = 1'b1;
        stallInc = 1'b1;
      end else begin
        en_c = '1;
      end
    end

    stall_d = (stallInc && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flushInc && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= CTRL_RUN;
      waitCnt_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs forced quiet while reset is held, so an aborted wait never
  // produces a start pulse or an enable.
  assign pcEn        = rstN && en_c.pc;
  assign idEn        = rstN && en_c.id;
  assign exEn        = rstN && en_c.ex;
  assign memEn       = rstN && en_c.mem;
  assign wbEn        = rstN && en_c.wb;
  assign idFlush     = rstN && fl_c.id;
  assign exFlush     = rstN && fl_c.ex;
  assign wbFlush     = rstN && fl_c.wb;
  assign memStart    = rstN && memStart_c;
  assign memTimeout  = timeout_q;
  assign ctrlState   = state_q;
  assign stallCycles = stall_q;
  assign flushCount  = flush_q;

endmodule
